// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
//   Command controller between UART2 and the signal-generator core. Parses
//   ASCII commands from the Rx byte stream and updates the generator config:
//     F<FREQ_W/4 hex digits>CR  frequency word (MSB digit first)
//     W<0..3>CR                 waveform select
//     E CR / D CR               output enable / disable
//   Letters are case-insensitive. Every parsed command is answered with
//   'K' (accepted) or '?' (rejected), followed by CR LF, on the Tx handshake.
//   A partial command that sees no byte for TIMEOUT cycles is dropped silently.
//
//   Build macro UART_CMD_ECHO_EN: echo every accepted byte back on Tx through
//   a one-byte holding register. An echo always goes out ahead of reply bytes.
//
// Ports
//   ipClk, ipReset            clock, asynchronous active-high reset
//   ipRxData/ipRxValid        received byte and its 1-cycle strobe
//   ipTxBusy                  UART transmitter busy
//   opTxData/opTxSend         byte and send request to the UART transmitter
//   opFreqWord/opWave/opEnable generator configuration registers
//   opCfgStrobe               1-cycle pulse whenever a config register is written
//   opBusy                    high while a command or reply is in progress
//   opRxOverrun               1-cycle pulse (registered) for every dropped byte
module uart_cmd_ctrl #(
   parameter int FREQ_W  = 32,
   parameter int TIMEOUT = 50_000_000
) (
   input  logic              ipClk,
   input  logic              ipReset,
   input  logic [7:0]        ipRxData,
   input  logic              ipRxValid,
   input  logic              ipTxBusy,
   output logic [7:0]        opTxData,
   output logic              opTxSend,
   output logic [FREQ_W-1:0] opFreqWord,
   output logic [1:0]        opWave,
   output logic              opEnable,
   output logic              opCfgStrobe,
   output logic              opBusy,
   output logic              opRxOverrun
);
   localparam int N  = FREQ_W / 4;
   localparam int CW = $clog2(N + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;

   typedef enum logic [2:0] {IDLE, GET_HEX, GET_WAVE, WAIT_CR, EXEC, ERR, RESP} state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_WAIT} tx_t;
   typedef enum logic [1:0] {CMD_FREQ, CMD_WAVE, CMD_EN, CMD_DIS} cmd_t;

   state_t            state, state_nxt;
   tx_t               tx_phase;
   cmd_t              cmd;
   logic [7:0]        tx_byte, resp_byte, lc;
   logic              tx_echo, resp_ok;
   logic [1:0]        resp_idx, wave_sh;
   logic [FREQ_W-1:0] freq_sh;
   logic [CW-1:0]     digits;
   logic [TW-1:0]     timer;
   logic [3:0]        hex_val;
   logic              hex_ok, timed_out, resp_done, accept, drop, ovr;
   logic              tx_free, start_echo, start_resp;
   logic              echo_pend;
   logic [7:0]        echo_data;

   // lc is the byte with the ASCII lower-case bit forced; only letters care.
   assign lc = ipRxData | 8'h20;

   function automatic state_t dispatch(input logic [7:0] c);
      case (c)
         "f":     return GET_HEX;
         "w":     return GET_WAVE;
         "e", "d": return WAIT_CR;
         default: return IDLE;   // stray bytes (LF, space, ...) ignored
      endcase
   endfunction

   always_comb begin
      hex_ok  = 1'b1;
      hex_val = ipRxData[3:0];
      if (ipRxData >= "0" && ipRxData <= "9") hex_val = ipRxData[3:0];
      else if (lc >= "a" && lc <= "f")        hex_val = lc[3:0] + 4'd9;
      else begin
         hex_ok  = 1'b0;
         hex_val = 4'd0;
      end
   end

   // Last reply byte finishing; a byte arriving on this cycle is parsed as if idle.
   assign resp_done = (state == RESP) && (tx_phase == TX_WAIT) && !tx_echo &&
                      !ipTxBusy && (resp_idx == 2'd2);
   assign timed_out = (timer == TW'(TIMEOUT - 1)) && !ipRxValid;
   assign accept    = ipRxValid && ((state inside {IDLE, GET_HEX, GET_WAVE, WAIT_CR}) || resp_done);
   assign drop      = ipRxValid && !accept;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (ipRxValid) state_nxt = dispatch(lc);
         GET_HEX:
            if (ipRxValid) begin
               if (ipRxData == CR)                     state_nxt = (digits == CW'(N)) ? EXEC : ERR;
               else if (!hex_ok || digits == CW'(N))   state_nxt = ERR;
            end else if (timed_out) state_nxt = IDLE;
         GET_WAVE:
            if (ipRxValid)      state_nxt = (ipRxData[7:2] == 6'b001100) ? WAIT_CR : ERR;
            else if (timed_out) state_nxt = IDLE;
         WAIT_CR:
            if (ipRxValid)      state_nxt = (ipRxData == CR) ? EXEC : ERR;
            else if (timed_out) state_nxt = IDLE;
         EXEC, ERR: state_nxt = RESP;
         RESP:     if (resp_done) state_nxt = ipRxValid ? dispatch(lc) : IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      case (resp_idx)
         2'd0:    resp_byte = resp_ok ? 8'h4B : 8'h3F;
         2'd1:    resp_byte = CR;
         default: resp_byte = LF;
      endcase
   end

   // One transmitter shared by echo and reply; a pending echo has priority.
   assign tx_free    = (tx_phase == TX_IDLE) && !ipTxBusy;
   assign start_echo = tx_free && echo_pend;
   assign start_resp = tx_free && !echo_pend && (state == RESP);

`ifdef UART_CMD_ECHO_EN
   always_ff @(posedge ipClk or posedge ipReset) begin
      if (ipReset) begin
         echo_pend <= 1'b0;
         echo_data <= 8'h00;
      end else begin
         if (start_echo) echo_pend <= 1'b0;
         if (accept) begin          // newest byte wins the holding register
            echo_pend <= 1'b1;
            echo_data <= ipRxData;
         end
      end
   end
   assign ovr = drop || (accept && echo_pend && !start_echo);
`else
   assign echo_pend = 1'b0;
   assign echo_data = 8'h00;
   assign ovr       = drop;
`endif

   always_ff @(posedge ipClk or posedge ipReset) begin
      if (ipReset) begin
         state       <= IDLE;
         tx_phase    <= TX_IDLE;
         cmd         <= CMD_FREQ;
         tx_byte     <= 8'h00;
         tx_echo     <= 1'b0;
         resp_idx    <= 2'd0;
         resp_ok     <= 1'b0;
         freq_sh     <= '0;
         digits      <= '0;
         wave_sh     <= 2'd0;
         timer       <= '0;
         opFreqWord  <= '0;
         opWave      <= 2'd0;
         opEnable    <= 1'b0;
         opCfgStrobe <= 1'b0;
         opRxOverrun <= 1'b0;
      end else begin
         state       <= state_nxt;
         opCfgStrobe <= (state_nxt == EXEC);
         opRxOverrun <= ovr;

         if (ipRxValid || !(state inside {GET_HEX, GET_WAVE, WAIT_CR})) timer <= '0;
         else                                                         timer <= timer + TW'(1);

         if (ipRxValid && (state == IDLE || resp_done)) begin
            digits  <= '0;
            freq_sh <= '0;
            case (lc)
               "w":     cmd <= CMD_WAVE;
               "e":     cmd <= CMD_EN;
               "d":     cmd <= CMD_DIS;
               default: cmd <= CMD_FREQ;
            endcase
         end
         if (state == GET_HEX && ipRxValid && hex_ok && digits != CW'(N)) begin
            freq_sh <= (freq_sh << 4) | FREQ_W'(hex_val);
            digits  <= digits + CW'(1);
         end
         if (state == GET_WAVE && ipRxValid) wave_sh <= ipRxData[1:0];

         // Registers change together with the strobe, one cycle after the CR.
         if (state_nxt == EXEC) begin
            case (cmd)
               CMD_FREQ: opFreqWord <= freq_sh;
               CMD_WAVE: opWave     <= wave_sh;
               CMD_EN:   opEnable   <= 1'b1;
               default:  opEnable   <= 1'b0;
            endcase
         end

         case (tx_phase)
            TX_IDLE:
               if (start_echo || start_resp) begin
                  tx_phase <= TX_REQ;
                  tx_echo  <= start_echo;
                  tx_byte  <= start_echo ? echo_data : resp_byte;
               end
            TX_REQ:  if (ipTxBusy) tx_phase <= TX_WAIT;
            TX_WAIT:
               if (!ipTxBusy) begin
                  tx_phase <= TX_IDLE;
                  if (!tx_echo) resp_idx <= resp_idx + 2'd1;
               end
            default: tx_phase <= TX_IDLE;
         endcase

         if (state_nxt == EXEC || state_nxt == ERR) begin
            resp_ok  <= (state_nxt == EXEC);
            resp_idx <= 2'd0;
         end
      end
   end

   assign opTxSend = (tx_phase == TX_REQ);
   assign opTxData = tx_byte;
   assign opBusy   = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed scenarios plus random commands. Expected
// Tx bytes, config writes and overrun counts come from a command-level model.
module tb_uart_cmd_ctrl;
   localparam int FREQ_W  = 32;
   localparam int TIMEOUT = 100;
`ifdef UART_CMD_ECHO_EN
   localparam int GAP  = 24;
   localparam bit ECHO = 1'b1;
`else
   localparam int GAP  = 4;
   localparam bit ECHO = 1'b0;
`endif
   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        ipRxData;
   logic              ipRxValid;
   logic              ipTxBusy;
   logic [7:0]        opTxData;
   logic              opTxSend;
   logic [FREQ_W-1:0] opFreqWord;
   logic [1:0]        opWave;
   logic              opEnable, opCfgStrobe, opBusy, opRxOverrun;

   always #5 clk = ~clk;

   uart_cmd_ctrl #(.FREQ_W(FREQ_W), .TIMEOUT(TIMEOUT)) dut (
      .ipClk(clk), .ipReset(rst), .ipRxData(ipRxData), .ipRxValid(ipRxValid),
      .ipTxBusy(ipTxBusy), .opTxData(opTxData), .opTxSend(opTxSend),
      .opFreqWord(opFreqWord), .opWave(opWave), .opEnable(opEnable),
      .opCfgStrobe(opCfgStrobe), .opBusy(opBusy), .opRxOverrun(opRxOverrun));

   int          n_checks = 0, n_fail = 0;
   logic [7:0]  exp_tx[$];
   logic [34:0] exp_cfg[$];
   logic [7:0]  cmd_q[$];
   int          ovr_seen = 0, exp_ovr = 0;
   int          uart_phase = 0;
   logic [31:0] m_freq = 0;
   logic [1:0]  m_wave = 0;
   logic        m_en = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit is_hex(input logic [7:0] c);
      return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
   endfunction
   function automatic logic [3:0] hex_of(input logic [7:0] c);
      logic [7:0] v;
      v = (c <= "9") ? c - "0" : (c | 8'h20) - "a" + 8'd10;
      return v[3:0];
   endfunction
   function automatic logic [7:0] hex_char(input int d, input bit lower);
      logic [7:0] c;
      c = (d < 10) ? 8'(48 + d) : 8'((lower ? 87 : 55) + d);
      return c;
   endfunction
   function automatic logic [7:0] letter(input logic [7:0] up);
      return $urandom_range(0, 1) ? up : (up | 8'h20);
   endfunction

   // UART transmitter model + Tx scoreboard monitor
   initial begin : uart
      int dly, bcnt;
      bit bad;
      logic [7:0] e;
      ipTxBusy = 1'b0;
      forever begin
         @(negedge clk);
         case (uart_phase)
            0: if (opTxSend && !rst) begin
                  if (exp_tx.size() == 0) begin
                     n_checks++; n_fail++;
                     $display("FAIL tx_unexpected: got %02h, queue empty", opTxData);
                  end else begin
                     e = exp_tx.pop_front();
                     check("tx_byte", opTxData, e);
                  end
                  dly = $urandom_range(0, 2);
                  uart_phase = 1;
               end
            1: if (dly == 0) begin
                  ipTxBusy = 1'b1; bcnt = $urandom_range(6, 10); bad = 0; uart_phase = 2;
               end else dly--;
            default: begin
               if (opTxSend) bad = 1;
               bcnt--;
               if (bcnt == 0) begin
                  ipTxBusy = 1'b0;
                  check("send_while_busy", bad, 0);
                  uart_phase = 0;
               end
            end
         endcase
      end
   end

   // Config write / overrun monitor
   initial begin : cfg_mon
      logic [34:0] e;
      forever begin
         @(negedge clk);
         if (opCfgStrobe) begin
            if (exp_cfg.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL cfg_unexpected: strobe with freq=%0h wave=%0d en=%0d", opFreqWord, opWave, opEnable);
            end else begin
               e = exp_cfg.pop_front();
               check("cfg_regs", {opFreqWord, opWave, opEnable}, e);
            end
         end
         if (opRxOverrun) ovr_seen++;
      end
   end

   initial begin : watchdog
      #(900_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1 ipRxData = b; ipRxValid = 1'b1;
      @(posedge clk); #1 ipRxValid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (opBusy && t < 3000) begin @(negedge clk); t++; end
      check("idle_reached", opBusy, 0);
      repeat (5) @(negedge clk);
   endtask

   task automatic load(input string s);
      cmd_q.delete();
      for (int i = 0; i < s.len(); i++) cmd_q.push_back(s[i]);
      cmd_q.push_back(CR);
   endtask

   // Command-level model: the command is valid only in its exact form; the
   // first byte that breaks the form is where the parser answers '?'.
   task automatic run_cmd(input bit trunc, input bit wait_done);
      int s, k, ep, nsend;
      bit ok;
      logic [31:0] v;
      logic [7:0]  c;
      s = 0;
      while (s < cmd_q.size() && !((cmd_q[s] | 8'h20) inside {"f", "w", "e", "d"})) s++;
      c = cmd_q[s] | 8'h20;
      ok = 0; v = 0;
      if (c == "f") begin
         k = s + 1;
         while (k < cmd_q.size() && is_hex(cmd_q[k])) begin
            if (k - s <= 8) v = {v[27:0], hex_of(cmd_q[k])};
            k++;
         end
         ok = (k == s + 9) && (cmd_q[k] == CR);
         ep = (k < s + 9) ? k : s + 9;
         if (ok) m_freq = v;
      end else if (c == "w") begin
         if (cmd_q[s+1] inside {"0", "1", "2", "3"}) begin
            ok = (cmd_q[s+2] == CR); ep = s + 2;
            if (ok) m_wave = cmd_q[s+1] - "0";
         end else ep = s + 1;
      end else begin
         ok = (cmd_q[s+1] == CR); ep = s + 1;
         if (ok) m_en = (c == "e");
      end
      nsend = trunc ? ep + 1 : cmd_q.size();
      if (ECHO) for (int i = 0; i <= ep; i++) exp_tx.push_back(cmd_q[i]);
      exp_tx.push_back(ok ? 8'h4B : 8'h3F);
      exp_tx.push_back(CR);
      exp_tx.push_back(LF);
      if (ok) exp_cfg.push_back({m_freq, m_wave, m_en});
      exp_ovr += nsend - ep - 1;
      for (int i = 0; i < nsend; i++) begin
         send_byte(cmd_q[i]);
         if (ok && i == ep) begin
            @(negedge clk);
            check("strobe_after_cr", opCfgStrobe, 1);
         end
         repeat (GAP) @(posedge clk);
      end
      if (wait_done) wait_idle();
   endtask

   task automatic gen_cmd();
      int kind, n;
      logic [31:0] v;
      cmd_q.delete();
      if ($urandom_range(0, 3) == 0) cmd_q.push_back($urandom_range(0, 1) ? 8'h20 : LF);
      kind = $urandom_range(0, 7);
      case (kind)
         0, 1: begin
            v = $urandom;
            cmd_q.push_back(letter("F"));
            for (int i = 7; i >= 0; i--) cmd_q.push_back(hex_char(int'(v[i*4 +: 4]), $urandom_range(0, 1)));
            cmd_q.push_back(CR);
         end
         2, 7: begin
            n = (kind == 2) ? $urandom_range(0, 7) : $urandom_range(9, 10);
            cmd_q.push_back(letter("F"));
            for (int i = 0; i < n; i++) cmd_q.push_back(hex_char($urandom_range(0, 15), $urandom_range(0, 1)));
            cmd_q.push_back(CR);
         end
         3: begin
            n = $urandom_range(0, 8);
            cmd_q.push_back(letter("F"));
            for (int i = 0; i < n; i++) cmd_q.push_back(hex_char($urandom_range(0, 15), 0));
            cmd_q.push_back($urandom_range(0, 1) ? "G" : "x");
            cmd_q.push_back(CR);
         end
         4: begin
            cmd_q.push_back(letter("W"));
            cmd_q.push_back(8'("0" + $urandom_range(0, 3)));
            cmd_q.push_back(CR);
         end
         5: begin
            cmd_q.push_back(letter("W"));
            if ($urandom_range(0, 1)) cmd_q.push_back(8'("4" + $urandom_range(0, 5)));
            else begin cmd_q.push_back("1"); cmd_q.push_back("z"); end
            cmd_q.push_back(CR);
         end
         default: begin
            cmd_q.push_back(letter($urandom_range(0, 1) ? "E" : "D"));
            cmd_q.push_back($urandom_range(0, 3) == 0 ? "Q" : CR);
         end
      endcase
   endtask

   initial begin : stim
      int t;
      rst = 1'b1; ipRxData = 8'h00; ipRxValid = 1'b0;
      #1;
      check("rst_txsend", opTxSend, 0);
      check("rst_outputs", {opTxData, opFreqWord, opWave, opEnable, opCfgStrobe, opBusy, opRxOverrun}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // 1: full frequency word
      load("F0000A000"); run_cmd(0, 1);
      check("freq_a000", opFreqWord, 32'h0000A000);
      @(negedge clk); check("strobe_one_cycle", opCfgStrobe, 0);

      // 2: waveform, valid and out of range
      load("W2"); run_cmd(0, 1);
      load("W7"); run_cmd(0, 1);
      check("wave_held", opWave, 2'd2);

      // 3: short and long frequency commands
      load("F12"); run_cmd(0, 1);
      load("F123456789"); run_cmd(0, 1);
      check("freq_held", opFreqWord, m_freq);
      check("overrun_t3", ovr_seen, exp_ovr);

      // 4: command during an active reply is dropped
      load("W1"); run_cmd(0, 0);
      send_byte("E"); repeat (2) @(posedge clk);
      send_byte(CR);
      exp_ovr += 2;
      wait_idle();
      check("overrun_t4", ovr_seen, exp_ovr);
      check("enable_still_off", opEnable, 0);
      load("e"); run_cmd(0, 1);
      check("enable_on", opEnable, 1);

      // 5: partial command times out silently
      cmd_q.delete(); cmd_q.push_back("F"); cmd_q.push_back("1"); cmd_q.push_back("2");
      for (int i = 0; i < 3; i++) begin
         send_byte(cmd_q[i]);
         if (ECHO) exp_tx.push_back(cmd_q[i]);
         repeat (GAP) @(posedge clk);
      end
      repeat (TIMEOUT / 2) @(negedge clk);
      check("busy_before_timeout", opBusy, 1);
      repeat (TIMEOUT) @(negedge clk);
      check("idle_after_timeout", opBusy, 0);
      check("freq_after_timeout", opFreqWord, m_freq);

      // Random commands; each truncated at its first bad byte
      for (int n = 0; n < 40; n++) begin
         gen_cmd();
         run_cmd(1, 1);
      end
      check("overrun_random", ovr_seen, exp_ovr);
      check("cfg_final", {opFreqWord, opWave, opEnable}, {m_freq, m_wave, m_en});

      // 6: reset in the middle of a reply with the transmitter busy
      load("E"); run_cmd(0, 0);
      t = 0;
      while (!(uart_phase == 2 && exp_tx.size() < 3) && t < 500) begin @(negedge clk); t++; end
      check("reply_in_flight", ipTxBusy, 1);
      #3 rst = 1'b1;
      #1;
      check("mid_reset_txsend", opTxSend, 0);
      check("mid_reset_busy", opBusy, 0);
      check("mid_reset_outputs", {opTxData, opFreqWord, opWave, opEnable, opCfgStrobe, opRxOverrun}, 0);
      exp_tx.delete();
      m_freq = 0; m_wave = 0; m_en = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      load("D"); run_cmd(0, 1);

      t = 0;
      while ((exp_tx.size() != 0 || uart_phase != 0) && t < 500) begin @(negedge clk); t++; end
      check("tx_queue_empty", exp_tx.size(), 0);
      check("cfg_queue_empty", exp_cfg.size(), 0);
      check("overrun_final", ovr_seen, exp_ovr);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
